// File: rtl/uart_tx_rr_sched_if.sv
// Bus between the round-robin scheduler, its byte requesters and the shared
// UART tx engine. The master modport is the scheduler side.
interface uart_tx_rr_sched_if #(
  parameter int NUM_REQ = 4
);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] data;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic                 timeout;
  logic [OW-1:0]        owner;
  logic                 busy;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_finish;
  logic                 tx_busy;

  modport master (
    input  req, data, tx_finish, tx_busy,
    output gnt, done, timeout, owner, busy, tx_start, tx_data
  );

  modport slave (
    output req, data, tx_finish, tx_busy,
    input  gnt, done, timeout, owner, busy, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_rr_sched.sv
// Round-robin scheduler sharing one single-byte UART tx engine between
// NUM_REQ requesters, with an optional post-byte idle gap and a completion
// watchdog.
//
// state  | meaning
// IDLE   | arbitrate pending requests while the engine is not busy
// LAUNCH | one cycle: engine start strobe and grant pulse to the owner
// WAIT   | wait for the engine finish pulse; watchdog counts here
// GAP    | enforced idle cycles after a completed byte
module uart_tx_rr_sched #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input logic               clk,
  input logic               rst,
  uart_tx_rr_sched_if.master bus
);
  localparam int OW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

  state_t        state;
  logic [31:0]   wd_cnt;
  logic [31:0]   gap_cnt;
  logic [31:0]   wd_inc;
  logic [31:0]   gap_inc;
  logic [OW-1:0] win;
  logic [OW-1:0] cand;

  // Saturating increments so a long stall can never wrap a counter.
  assign wd_inc  = (wd_cnt  == 32'hFFFF_FFFF) ? wd_cnt  : wd_cnt  + 32'd1;
  assign gap_inc = (gap_cnt == 32'hFFFF_FFFF) ? gap_cnt : gap_cnt + 32'd1;

  // Winner: first set request after the last owner, wrapping. The scan runs
  // from the farthest candidate back so the nearest one is assigned last.
  // The last owner doubles as the round-robin pointer.
  always_comb begin
    win  = bus.owner;
    cand = bus.owner;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = OW'((32'(bus.owner) + 32'(k)) % 32'(NUM_REQ));
      if (bus.req[cand]) win = cand;
    end
  end

  // Scheduler FSM; every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wd_cnt       <= '0;
      gap_cnt      <= '0;
      bus.gnt      <= '0;
      bus.done     <= '0;
      bus.timeout  <= 1'b0;
      bus.owner    <= OW'(NUM_REQ - 1);
      bus.busy     <= 1'b0;
      bus.tx_start <= 1'b0;
      bus.tx_data  <= 8'h00;
    end else begin
      bus.gnt      <= '0;
      bus.done     <= '0;
      bus.timeout  <= 1'b0;
      bus.tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if ((|bus.req) && !bus.tx_busy) begin
            bus.owner    <= win;
            bus.tx_data  <= bus.data[{win, 3'b000} +: 8];
            bus.tx_start <= 1'b1;
            bus.gnt      <= ONE << win;
            bus.busy     <= 1'b1;
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          // A finish in the same cycle the watchdog expires takes priority.
          if (bus.tx_finish) begin
            bus.done <= ONE << bus.owner;
            if (GAP_CYCLES > 0) begin
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              bus.busy <= 1'b0;
              state    <= IDLE;
            end
          end else if (TIMEOUT_CYCLES != 0 && wd_inc == 32'(TIMEOUT_CYCLES)) begin
            bus.timeout <= 1'b1;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_inc;
          end
        end
        GAP: begin
          if (gap_inc >= 32'(GAP_CYCLES)) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            gap_cnt <= gap_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
